// File: rtl/tlb_miss_queue.sv
// tlb_miss_queue: miss buffer between one L1 TLB and the L2 TLB request port.
// It collects L1 misses and merges duplicates by VPN. It issues one L2 request
// at a time, oldest first. It broadcasts a one-cycle refill when the in-flight
// VPN returns.
//
// Handshakes: a miss is taken in any cycle where miss_valid & miss_ready.
// miss_ready is combinational and does not depend on miss_valid. An L2
// request transfers in any cycle where l2_req & l2_ready. The request
// fields stay stable while l2_req=1 and l2_ready=0. A response has no ready
// and is consumed only when its VPN matches the in-flight entry.
module tlb_miss_queue #(
  parameter int ENTRIES = 4,
  parameter int VPN_W   = 27,
  parameter int PPN_W   = 44,
  parameter int SRC_W   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         miss_valid,
  input  logic [VPN_W-1:0]             miss_vpn,
  input  logic [SRC_W-1:0]             miss_src,
  output logic                         miss_ready,
  output logic                         l2_req,
  output logic [VPN_W-1:0]             l2_req_vpn,
  output logic [SRC_W-1:0]             l2_req_src,
  input  logic                         l2_ready,
  input  logic                         l2_rsp_valid,
  input  logic [VPN_W-1:0]             l2_rsp_vpn,
  input  logic [PPN_W-1:0]             l2_rsp_ppn,
  input  logic                         l2_rsp_exception,
  output logic                         refill_valid,
  output logic [VPN_W-1:0]             refill_vpn,
  output logic [PPN_W-1:0]             refill_ppn,
  output logic                         refill_exception,
  output logic [$clog2(ENTRIES):0]     pending,
  output logic [2*ENTRIES-1:0]         state_dbg
);

  localparam int IW = $clog2(ENTRIES);
  localparam int AW = IW + 1;

  typedef enum logic [1:0] {
    ST_FREE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_INFLIGHT = 2'd2
  } entry_state_e;

  entry_state_e     state_q [ENTRIES];
  entry_state_e     state_n [ENTRIES];
  logic [VPN_W-1:0] vpn_q   [ENTRIES];
  logic [SRC_W-1:0] src_q   [ENTRIES];
  logic [AW-1:0]    age_q   [ENTRIES];
  logic [AW-1:0]    age_cnt_q;

  logic          match, any_free, any_wait, any_inflight;
  logic [IW-1:0] free_idx, oldest_idx, infl_idx;
  logic [AW-1:0] rel_age, best_rel;
  logic [AW-1:0] pending_n;
  logic          alloc, issue, rsp_hit;

  // Scan entries: VPN match, lowest free slot, in-flight slot, and oldest waiter.
  // Age is taken relative to the allocation counter. The live ages span at most
  // ENTRIES values below it, so the smallest wrapped difference is the oldest.
  always_comb begin
    match        = 1'b0;
    any_free     = 1'b0;
    any_wait     = 1'b0;
    any_inflight = 1'b0;
    free_idx     = '0;
    oldest_idx   = '0;
    infl_idx     = '0;
    rel_age      = '0;
    best_rel     = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (state_q[i] == ST_FREE) begin
        if (!any_free) free_idx = IW'(i);
        any_free = 1'b1;
      end else if (vpn_q[i] == miss_vpn) begin
        match = 1'b1;
      end
      if (state_q[i] == ST_INFLIGHT) begin
        any_inflight = 1'b1;
        infl_idx     = IW'(i);
      end
      if (state_q[i] == ST_WAIT) begin
        rel_age = age_q[i] - age_cnt_q;
        if (!any_wait || rel_age < best_rel) begin
          best_rel   = rel_age;
          oldest_idx = IW'(i);
        end
        any_wait = 1'b1;
      end
    end
  end

  // Handshake decode and request presentation from the stored entry fields.
  always_comb begin
    miss_ready = !flush && (match || any_free);
    alloc      = miss_valid && !flush && !match && any_free;
    l2_req     = !flush && !any_inflight && any_wait;
    l2_req_vpn = vpn_q[oldest_idx];
    l2_req_src = src_q[oldest_idx];
    issue      = l2_req && l2_ready;
    rsp_hit    = l2_rsp_valid && any_inflight && (l2_rsp_vpn == vpn_q[infl_idx]);
  end

  // Per-entry next state and the occupancy count it implies.
  always_comb begin
    pending_n = '0;
    state_dbg = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      state_n[i] = state_q[i];
      if (flush) begin
        state_n[i] = ST_FREE;
      end else begin
        if (alloc && free_idx == IW'(i))   state_n[i] = ST_WAIT;
        if (issue && oldest_idx == IW'(i)) state_n[i] = ST_INFLIGHT;
        if (rsp_hit && infl_idx == IW'(i)) state_n[i] = ST_FREE;
      end
      if (state_n[i] != ST_FREE) pending_n = pending_n + AW'(1);
      state_dbg[2*i +: 2] = state_q[i];
    end
  end

  // Entry state register and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) state_q[i] <= ST_FREE;
      pending <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) state_q[i] <= state_n[i];
      pending <= pending_n;
    end
  end

  // Entry payload and age tag; written only when a slot is allocated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        vpn_q[i] <= '0;
        src_q[i] <= '0;
        age_q[i] <= '0;
      end
      age_cnt_q <= '0;
    end else if (alloc) begin
      vpn_q[free_idx] <= miss_vpn;
      src_q[free_idx] <= miss_src;
      age_q[free_idx] <= age_cnt_q;
      age_cnt_q       <= age_cnt_q + AW'(1);
    end
  end

  // Refill pulse one cycle after a matching response; a flush cancels it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refill_valid     <= 1'b0;
      refill_vpn       <= '0;
      refill_ppn       <= '0;
      refill_exception <= 1'b0;
    end else begin
      refill_valid <= rsp_hit && !flush;
      if (rsp_hit) begin
        refill_vpn       <= l2_rsp_vpn;
        refill_ppn       <= l2_rsp_ppn;
        refill_exception <= l2_rsp_exception;
      end
    end
  end

endmodule

// File: tb/tb_tlb_miss_queue.sv
// Directed bench for tlb_miss_queue with the default parameters
// (4 entries, 27-bit VPN, 44-bit PPN, 2-bit source).
module tb_tlb_miss_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        miss_valid = 1'b0;
  logic [26:0] miss_vpn = '0;
  logic [1:0]  miss_src = '0;
  logic        miss_ready;
  logic        l2_req;
  logic [26:0] l2_req_vpn;
  logic [1:0]  l2_req_src;
  logic        l2_ready = 1'b0;
  logic        l2_rsp_valid = 1'b0;
  logic [26:0] l2_rsp_vpn = '0;
  logic [43:0] l2_rsp_ppn = '0;
  logic        l2_rsp_exception = 1'b0;
  logic        refill_valid;
  logic [26:0] refill_vpn;
  logic [43:0] refill_ppn;
  logic        refill_exception;
  logic [2:0]  pending;
  logic [7:0]  state_dbg;

  int          errors = 0;
  int          checks = 0;
  logic [26:0] exp_q[$];
  logic [26:0] ev;

  tlb_miss_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .miss_valid(miss_valid), .miss_vpn(miss_vpn), .miss_src(miss_src),
    .miss_ready(miss_ready),
    .l2_req(l2_req), .l2_req_vpn(l2_req_vpn), .l2_req_src(l2_req_src),
    .l2_ready(l2_ready),
    .l2_rsp_valid(l2_rsp_valid), .l2_rsp_vpn(l2_rsp_vpn),
    .l2_rsp_ppn(l2_rsp_ppn), .l2_rsp_exception(l2_rsp_exception),
    .refill_valid(refill_valid), .refill_vpn(refill_vpn),
    .refill_ppn(refill_ppn), .refill_exception(refill_exception),
    .pending(pending), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge (input drive point)
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge (sample point)
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset ----------------
    cyc();
    chk("rst_miss_ready", 64'(miss_ready), 64'd1);
    chk("rst_l2_req", 64'(l2_req), 64'd0);
    chk("rst_refill_valid", 64'(refill_valid), 64'd0);
    chk("rst_refill_vpn", 64'(refill_vpn), 64'd0);
    chk("rst_refill_ppn", 64'(refill_ppn), 64'd0);
    chk("rst_refill_exc", 64'(refill_exception), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    rst = 1'b0;
    cyc();

    // ---------------- single miss ----------------
    miss_valid = 1'b1; miss_vpn = 27'h1234; miss_src = 2'd0;
    settle();
    chk("t1_miss_ready", 64'(miss_ready), 64'd1);
    chk("t1_no_req_yet", 64'(l2_req), 64'd0);
    cyc();
    miss_valid = 1'b0; l2_ready = 1'b1;
    settle();
    chk("t1_req", 64'(l2_req), 64'd1);
    chk("t1_req_vpn", 64'(l2_req_vpn), 64'h1234);
    chk("t1_req_src", 64'(l2_req_src), 64'd0);
    chk("t1_pending", 64'(pending), 64'd1);
    cyc();
    l2_ready = 1'b0;
    settle();
    chk("t1_req_drop", 64'(l2_req), 64'd0);
    chk("t1_inflight", 64'(state_dbg[1:0]), 64'd2);
    cyc(); cyc(); cyc();
    l2_rsp_valid = 1'b1; l2_rsp_vpn = 27'h1234; l2_rsp_ppn = 44'hABCD; l2_rsp_exception = 1'b0;
    settle();
    chk("t1_no_early_refill", 64'(refill_valid), 64'd0);
    cyc();
    l2_rsp_valid = 1'b0;
    settle();
    chk("t1_refill_valid", 64'(refill_valid), 64'd1);
    chk("t1_refill_vpn", 64'(refill_vpn), 64'h1234);
    chk("t1_refill_ppn", 64'(refill_ppn), 64'hABCD);
    chk("t1_refill_exc", 64'(refill_exception), 64'd0);
    chk("t1_pending0", 64'(pending), 64'd0);
    cyc();
    settle();
    chk("t1_refill_pulse", 64'(refill_valid), 64'd0);
    cyc();

    // ---------------- merge ----------------
    miss_valid = 1'b1; miss_vpn = 27'h10; miss_src = 2'd1;
    cyc();
    settle();
    chk("t2_merge_ready", 64'(miss_ready), 64'd1);
    chk("t2_req_vpn", 64'(l2_req_vpn), 64'h10);
    cyc();
    miss_valid = 1'b0; l2_ready = 1'b1;
    settle();
    chk("t2_pending1", 64'(pending), 64'd1);
    chk("t2_req", 64'(l2_req), 64'd1);
    chk("t2_req_src", 64'(l2_req_src), 64'd1);
    cyc();
    l2_ready = 1'b0;
    l2_rsp_valid = 1'b1; l2_rsp_vpn = 27'h10; l2_rsp_ppn = 44'h55; l2_rsp_exception = 1'b1;
    settle();
    chk("t2_single_req", 64'(l2_req), 64'd0);
    cyc();
    l2_rsp_valid = 1'b0; l2_rsp_exception = 1'b0;
    settle();
    chk("t2_refill_valid", 64'(refill_valid), 64'd1);
    chk("t2_refill_ppn", 64'(refill_ppn), 64'h55);
    chk("t2_refill_exc", 64'(refill_exception), 64'd1);
    chk("t2_pending0", 64'(pending), 64'd0);
    cyc();
    settle();
    chk("t2_one_refill", 64'(refill_valid), 64'd0);
    chk("t2_no_second_req", 64'(l2_req), 64'd0);
    cyc();

    // ---------------- mismatched response ----------------
    miss_valid = 1'b1; miss_vpn = 27'h20; miss_src = 2'd2;
    cyc();
    miss_valid = 1'b0; l2_ready = 1'b1;
    cyc();
    l2_ready = 1'b0;
    l2_rsp_valid = 1'b1; l2_rsp_vpn = 27'h21; l2_rsp_ppn = 44'h77;
    cyc();
    l2_rsp_valid = 1'b0;
    settle();
    chk("t4_no_refill", 64'(refill_valid), 64'd0);
    chk("t4_pending", 64'(pending), 64'd1);
    chk("t4_still_inflight", 64'(state_dbg[1:0]), 64'd2);
    chk("t4_no_reissue", 64'(l2_req), 64'd0);
    cyc();
    l2_rsp_valid = 1'b1; l2_rsp_vpn = 27'h20; l2_rsp_ppn = 44'h88;
    cyc();
    l2_rsp_valid = 1'b0;
    settle();
    chk("t4_refill_valid", 64'(refill_valid), 64'd1);
    chk("t4_refill_vpn", 64'(refill_vpn), 64'h20);
    chk("t4_refill_ppn", 64'(refill_ppn), 64'h88);
    cyc();

    // ---------------- flush mid-flight ----------------
    miss_valid = 1'b1; miss_vpn = 27'h30; miss_src = 2'd0;
    cyc();
    miss_valid = 1'b0; l2_ready = 1'b1;
    cyc();
    l2_ready = 1'b0;
    flush = 1'b1; miss_valid = 1'b1; miss_vpn = 27'h31;
    settle();
    chk("t5_flush_miss_ready", 64'(miss_ready), 64'd0);
    cyc();
    flush = 1'b0; miss_valid = 1'b0;
    settle();
    chk("t5_pending0", 64'(pending), 64'd0);
    cyc();
    l2_rsp_valid = 1'b1; l2_rsp_vpn = 27'h30; l2_rsp_ppn = 44'h33;
    cyc();
    l2_rsp_valid = 1'b0;
    settle();
    chk("t5_stale_rsp_ignored", 64'(refill_valid), 64'd0);
    chk("t5_pending_stays0", 64'(pending), 64'd0);
    cyc();
    // waiting entry flushed while requesting
    miss_valid = 1'b1; miss_vpn = 27'h41; miss_src = 2'd1;
    cyc();
    miss_valid = 1'b0; flush = 1'b1;
    settle();
    chk("t5_req_off_in_flush", 64'(l2_req), 64'd0);
    cyc();
    flush = 1'b0;
    settle();
    chk("t5_flushed_wait", 64'(pending), 64'd0);
    chk("t5_no_req_after", 64'(l2_req), 64'd0);
    cyc();
    miss_valid = 1'b1; miss_vpn = 27'h40; miss_src = 2'd3;
    cyc();
    miss_valid = 1'b0; l2_ready = 1'b1;
    settle();
    chk("t5_new_req_vpn", 64'(l2_req_vpn), 64'h40);
    chk("t5_new_req_src", 64'(l2_req_src), 64'd3);
    cyc();
    l2_ready = 1'b0;
    l2_rsp_valid = 1'b1; l2_rsp_vpn = 27'h40; l2_rsp_ppn = 44'h4444;
    cyc();
    l2_rsp_valid = 1'b0;
    settle();
    chk("t5_new_refill", 64'(refill_valid), 64'd1);
    chk("t5_new_refill_ppn", 64'(refill_ppn), 64'h4444);
    cyc();

    // ---------------- same-cycle miss and matching response ----------------
    miss_valid = 1'b1; miss_vpn = 27'h50; miss_src = 2'd2;
    cyc();
    miss_valid = 1'b0; l2_ready = 1'b1;
    cyc();
    l2_ready = 1'b0;
    miss_valid = 1'b1; miss_vpn = 27'h50;
    l2_rsp_valid = 1'b1; l2_rsp_vpn = 27'h50; l2_rsp_ppn = 44'h5050;
    settle();
    chk("t6_miss_ready", 64'(miss_ready), 64'd1);
    chk("t6_pending1", 64'(pending), 64'd1);
    cyc();
    miss_valid = 1'b0; l2_rsp_valid = 1'b0;
    settle();
    chk("t6_refill_valid", 64'(refill_valid), 64'd1);
    chk("t6_refill_ppn", 64'(refill_ppn), 64'h5050);
    chk("t6_no_alloc", 64'(pending), 64'd0);
    cyc();
    settle();
    chk("t6_single_refill", 64'(refill_valid), 64'd0);
    chk("t6_no_req", 64'(l2_req), 64'd0);
    cyc();

    // ---------------- full / backpressure / issue order (age wraps here) ----
    for (int v = 1; v <= 4; v++) begin
      miss_valid = 1'b1; miss_vpn = 27'(v); miss_src = 2'(v);
      settle();
      chk("t3_fill_ready", 64'(miss_ready), 64'd1);
      cyc();
      exp_q.push_back(27'(v));
    end
    miss_vpn = 27'h5; miss_src = 2'd1;
    settle();
    chk("t3_full_ready", 64'(miss_ready), 64'd0);
    cyc();
    miss_vpn = 27'h3; miss_src = 2'd1;
    settle();
    chk("t3_full_merge_ready", 64'(miss_ready), 64'd1);
    chk("t3_pending4", 64'(pending), 64'd4);
    cyc();
    miss_valid = 1'b0;
    settle();
    chk("t3_pending_held", 64'(pending), 64'd4);
    for (int k = 0; k < 4; k++) begin
      ev = exp_q.pop_front();
      chk("t3_order_req", 64'(l2_req), 64'd1);
      chk("t3_order_vpn", 64'(l2_req_vpn), 64'(ev));
      chk("t3_order_src", 64'(l2_req_src), 64'(ev[1:0]));
      l2_ready = 1'b1;
      cyc();
      l2_ready = 1'b0;
      l2_rsp_valid = 1'b1; l2_rsp_vpn = ev; l2_rsp_ppn = 44'h100 + 44'(ev);
      cyc();
      l2_rsp_valid = 1'b0;
      settle();
      chk("t3_refill_vpn", 64'(refill_vpn), 64'(ev));
      chk("t3_refill_ppn", 64'(refill_ppn), 64'h100 + 64'(ev));
    end
    chk("t3_drained", 64'(pending), 64'd0);
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);
    cyc();

    // ---------------- flush cancels a refill due next cycle ----------------
    miss_valid = 1'b1; miss_vpn = 27'h60; miss_src = 2'd0;
    cyc();
    miss_valid = 1'b0; l2_ready = 1'b1;
    settle();
    chk("t7_req_vpn", 64'(l2_req_vpn), 64'h60);
    cyc();
    l2_ready = 1'b0; flush = 1'b1;
    l2_rsp_valid = 1'b1; l2_rsp_vpn = 27'h60; l2_rsp_ppn = 44'h66;
    cyc();
    flush = 1'b0; l2_rsp_valid = 1'b0;
    settle();
    chk("t7_refill_suppressed", 64'(refill_valid), 64'd0);
    chk("t7_pending0", 64'(pending), 64'd0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
